// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Brief    : Round-robin share of one multi-cycle FPU between two requesters.
//            Optional watchdog while waiting on the FPU: FPU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [7:0]           req_op,
    input  logic [63:0]          req_a,
    input  logic [63:0]          req_b,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [1:0]           rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 fpu_start,
    output logic [3:0]           fpu_op,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    input  logic [31:0]          fpu_result,
    input  logic                 fpu_valid,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef FPU_TIMEOUT_EN
    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0]           r_tmo_cnt;
`endif

    logic [1:0]       r_state;
    logic             r_rr_last;
    logic             r_src;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;
    logic             r_err;

    logic             w_gnt_any;
    logic             w_gnt_idx;
    logic             w_supported;

    // With both requesting, the one that did not win last time goes next.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 1'b0;
        case (req_valid)
            2'b01:   begin w_gnt_any = 1'b1; w_gnt_idx = 1'b0;       end
            2'b10:   begin w_gnt_any = 1'b1; w_gnt_idx = 1'b1;       end
            2'b11:   begin w_gnt_any = 1'b1; w_gnt_idx = ~r_rr_last; end
            default: begin w_gnt_any = 1'b0; w_gnt_idx = 1'b0;       end
        endcase
    end

    always_comb begin
        w_supported = 1'b0;
        case (r_op)
            4'b0011, 4'b0100, 4'b1110, 4'b1101,
            4'b1100, 4'b1011, 4'b1010: w_supported = 1'b1;
            default:                   w_supported = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_rr_last <= 1'b1;
            r_src     <= 1'b0;
            r_op      <= 4'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_tag     <= '0;
            r_data    <= 32'd0;
            r_err     <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_any) begin
                        r_src     <= w_gnt_idx;
                        r_rr_last <= w_gnt_idx;
                        r_op      <= w_gnt_idx ? req_op[7:4]   : req_op[3:0];
                        r_a       <= w_gnt_idx ? req_a[63:32]  : req_a[31:0];
                        r_b       <= w_gnt_idx ? req_b[63:32]  : req_b[31:0];
                        r_tag     <= w_gnt_idx ? req_tag[2*TAG_W-1:TAG_W]
                                               : req_tag[TAG_W-1:0];
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_supported) begin
                        r_state   <= c_WAIT;
`ifdef FPU_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end else begin
                        r_data  <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end
                end
                c_WAIT: begin
                    if (fpu_valid) begin
                        r_data  <= fpu_result;
                        r_err   <= 1'b0;
                        r_state <= c_RESP;
                    end
`ifdef FPU_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_data  <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Operands reach the FPU only while an op is in flight.
    always_comb begin
        req_ready = 2'b00;
        if (r_state == c_IDLE && w_gnt_any)
            req_ready = w_gnt_idx ? 2'b10 : 2'b01;
    end

    assign fpu_start = (r_state == c_ISSUE) && w_supported;
    assign fpu_op    = (r_state == c_ISSUE || r_state == c_WAIT) ? r_op : 4'd0;
    assign fpu_a     = (r_state == c_ISSUE || r_state == c_WAIT) ? r_a  : 32'd0;
    assign fpu_b     = (r_state == c_ISSUE || r_state == c_WAIT) ? r_b  : 32'd0;

    assign rsp_valid = (r_state == c_RESP) ? (r_src ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = (r_state == c_RESP) ? r_data : 32'd0;
    assign rsp_tag   = (r_state == c_RESP) ? r_tag  : '0;
    assign rsp_err   = (r_state == c_RESP) && r_err;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Brief    : Directed self-checking bench for fpu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

    localparam int TAG_W = 4;

    logic               CLK = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [7:0]         req_op;
    logic [63:0]        req_a;
    logic [63:0]        req_b;
    logic [2*TAG_W-1:0] req_tag;
    logic [1:0]         rsp_valid;
    logic [31:0]        rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_err;
    logic               fpu_start;
    logic [3:0]         fpu_op;
    logic [31:0]        fpu_a;
    logic [31:0]        fpu_b;
    logic [31:0]        fpu_result;
    logic               fpu_valid;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    fpu_arbiter #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_valid(fpu_valid), .busy(busy)
    );

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1; req_valid = 2'b00; fpu_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [111:0] got;
        tick();
        reset = 1'b1; req_valid = 2'b00; fpu_valid = 1'b0;
        tick();
        tick();
        #1;
        got = {req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, fpu_start,
               fpu_op, fpu_a, fpu_b, busy};
        n_total++;
        if (got !== '0) $display("FAIL reset_outputs got=%h want=0", got);
        else n_pass++;
        reset = 1'b0;
    endtask

    // One op from a single requester with an FPU that answers after lat cycles.
    task automatic run_op(input string name, input logic src, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int lat,
                          input logic [31:0] res);
        logic [1:0]  oh;
        logic [38:0] got, want;
        oh = src ? 2'b10 : 2'b01;
        tick();
        req_valid = oh;
        req_op    = src ? {op, 4'h0} : {4'h0, op};
        req_a     = src ? {a, 32'h0} : {32'h0, a};
        req_b     = src ? {b, 32'h0} : {32'h0, b};
        req_tag   = src ? {tag, 4'h0} : {4'h0, tag};
        #1;
        n_total++;
        if (req_ready !== oh || fpu_start !== 1'b0)
            $display("FAIL %s_accept ready=%b start=%b want ready=%b start=0", name, req_ready, fpu_start, oh);
        else n_pass++;
        tick();
        req_valid = 2'b00;
        #1;
        n_total++;
        if ({fpu_start, fpu_op, fpu_a, fpu_b, busy} !== {1'b1, op, a, b, 1'b1})
            $display("FAIL %s_issue start=%b op=%h a=%h b=%h busy=%b want op=%h a=%h b=%h",
                     name, fpu_start, fpu_op, fpu_a, fpu_b, busy, op, a, b);
        else n_pass++;
        for (int k = 2; k <= lat; k++) begin
            tick();
            #1;
            n_total++;
            if (fpu_start !== 1'b0 || fpu_a !== a || rsp_valid !== 2'b00)
                $display("FAIL %s_wait start=%b a=%h rsp_valid=%b want start=0 a=%h rsp_valid=00",
                         name, fpu_start, fpu_a, rsp_valid, a);
            else n_pass++;
        end
        tick();
        fpu_valid = 1'b1; fpu_result = res;
        tick();
        fpu_valid = 1'b0; fpu_result = 32'h0;
        #1;
        got  = {rsp_valid, rsp_err, rsp_tag, rsp_data};
        want = {oh, 1'b0, tag, res};
        n_total++;
        if (got !== want || fpu_a !== 32'h0)
            $display("FAIL %s_resp got=%h fpu_a=%h want=%h fpu_a=0", name, got, fpu_a, want);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL %s_idle rsp_valid=%b busy=%b want 00/0", name, rsp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        run_op("single", 1'b0, 4'b0011, 32'h3F800000, 32'h40000000, 4'h5, 3, 32'h40400000);
    endtask

    task automatic test_compare();
        run_op("cmp", 1'b1, 4'b1010, 32'h3F800000, 32'h40000000, 4'hC, 2, 32'h00000001);
    endtask

    task automatic test_contention();
        logic        g;
        logic [1:0]  oh;
        logic [38:0] got, want;
        apply_reset();
        req_valid = 2'b11;
        req_op    = {4'b1110, 4'b0011};
        req_a     = {32'hBBBB0001, 32'hAAAA0000};
        req_b     = {32'h22220001, 32'h11110000};
        req_tag   = {4'h9, 4'h6};
        for (int k = 0; k < 4; k++) begin
            g  = k[0];
            oh = g ? 2'b10 : 2'b01;
            #1;
            n_total++;
            if (req_ready !== oh)
                $display("FAIL rr_grant%0d ready=%b want=%b", k, req_ready, oh);
            else n_pass++;
            tick();
            #1;
            n_total++;
            if ({fpu_start, fpu_op, fpu_a, req_ready} !==
                {1'b1, g ? 4'b1110 : 4'b0011, g ? 32'hBBBB0001 : 32'hAAAA0000, 2'b00})
                $display("FAIL rr_issue%0d start=%b op=%h a=%h ready=%b", k, fpu_start, fpu_op, fpu_a, req_ready);
            else n_pass++;
            tick();
            fpu_valid = 1'b1; fpu_result = 32'h1000 + k;
            tick();
            fpu_valid = 1'b0;
            #1;
            got  = {rsp_valid, rsp_err, rsp_tag, rsp_data};
            want = {oh, 1'b0, g ? 4'h9 : 4'h6, 32'h1000 + k};
            n_total++;
            if (got !== want || req_ready !== 2'b00)
                $display("FAIL rr_resp%0d got=%h ready=%b want=%h ready=00", k, got, req_ready, want);
            else n_pass++;
            if (k == 3) req_valid = 2'b00;
            tick();
        end
    endtask

    task automatic test_unsupported();
        logic [38:0] got;
        tick();
        req_valid = 2'b01; req_op = 8'h00; req_a = 64'h1; req_b = 64'h2; req_tag = 8'h07;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL unsup_accept ready=%b want=01", req_ready);
        else n_pass++;
        tick();
        req_valid = 2'b00;
        #1;
        n_total++;
        if (fpu_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL unsup_nostart start=%b busy=%b want 0/1", fpu_start, busy);
        else n_pass++;
        tick();
        #1;
        got = {rsp_valid, rsp_err, rsp_tag, rsp_data};
        n_total++;
        if (got !== {2'b01, 1'b1, 4'h7, 32'h0})
            $display("FAIL unsup_resp got=%h want=%h", got, {2'b01, 1'b1, 4'h7, 32'h0});
        else n_pass++;
        tick();
        fpu_valid = 1'b1; fpu_result = 32'hDEADBEEF;
        tick();
        fpu_valid = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 32'h0)
            $display("FAIL stray_valid rsp_valid=%b busy=%b data=%h want 00/0/0", rsp_valid, busy, rsp_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        tick();
        req_valid = 2'b01; req_op = 8'h03; req_a = 64'h3F800000; req_b = 64'h40000000; req_tag = 8'h03;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        n_total++;
        if (busy !== 1'b1 || fpu_op !== 4'h3) $display("FAIL mid_wait busy=%b op=%h want 1/3", busy, fpu_op);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; fpu_valid = 1'b1; fpu_result = 32'h12345678;
        #1;
        n_total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00)
            $display("FAIL mid_reset busy=%b rsp_valid=%b want 0/00", busy, rsp_valid);
        else n_pass++;
        tick();
        fpu_valid = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL mid_late rsp_valid=%b busy=%b want 00/0", rsp_valid, busy);
        else n_pass++;
        tick();
        req_valid = 2'b11; req_op = 8'h43; req_tag = 8'h21;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL mid_regrant ready=%b want=01", req_ready);
        else n_pass++;
        tick();
        req_valid = 2'b00;
        tick();
        fpu_valid = 1'b1; fpu_result = 32'h55;
        tick();
        fpu_valid = 1'b0;
        #1;
        n_total++;
        if ({rsp_valid, rsp_tag, rsp_data} !== {2'b01, 4'h1, 32'h55})
            $display("FAIL mid_drain got=%h want=%h", {rsp_valid, rsp_tag, rsp_data}, {2'b01, 4'h1, 32'h55});
        else n_pass++;
        tick();
    endtask

`ifdef FPU_TIMEOUT_EN
    task automatic test_timeout();
        logic [38:0] got;
        tick();
        req_valid = 2'b01; req_op = 8'h0E; req_a = 64'h4; req_b = 64'h5; req_tag = 8'h0A;
        tick();
        req_valid = 2'b00;
        #1;
        n_total++;
        if (fpu_start !== 1'b1) $display("FAIL tmo_start start=%b want=1", fpu_start);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            n_total++;
            if (rsp_valid !== 2'b00 || busy !== 1'b1)
                $display("FAIL tmo_wait%0d rsp_valid=%b busy=%b want 00/1", k, rsp_valid, busy);
            else n_pass++;
        end
        tick();
        #1;
        got = {rsp_valid, rsp_err, rsp_tag, rsp_data};
        n_total++;
        if (got !== {2'b01, 1'b1, 4'hA, 32'h0})
            $display("FAIL tmo_resp got=%h want=%h", got, {2'b01, 1'b1, 4'hA, 32'h0});
        else n_pass++;
        tick();
        fpu_valid = 1'b1; fpu_result = 32'h77;
        tick();
        fpu_valid = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL tmo_late rsp_valid=%b busy=%b want 00/0", rsp_valid, busy);
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_op = 8'h0; req_a = 64'h0; req_b = 64'h0;
        req_tag = '0; fpu_result = 32'h0; fpu_valid = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_compare();
        test_unsupported();
        test_reset_mid();
`ifdef FPU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares the single multi-cycle FPU datapath between two requesters: port 0 is the core execute stage, port 1 is the vector/coprocessor side.
- Accepts one op at a time using round-robin arbitration and drives the FPU with a start pulse.
- Waits for the FPU's result-valid pulse, then routes the result back to the requester that issued the op, together with that requester's tag.
- Sits between the decode/execute stages and the FPU.

Parameters:
- TAG_W, 4, width of the per-request tag echoed back in the response.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles while waiting for the FPU (used only with FPU_TIMEOUT_EN).

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_op  in  8  ALUOp per requester, [3:0]=req0, [7:4]=req1
- req_a  in  64  operand A per requester, [31:0]=req0
- req_b  in  64  operand B per requester, [31:0]=req0
- req_tag  in  2*TAG_W  tag per requester
- rsp_valid  out  2  one-cycle response pulse to requester i
- rsp_data  out  32  result (compares: {31'b0,bit})
- rsp_tag  out  TAG_W  echoed tag
- rsp_err  out  1  unsupported op or timeout; qualifies rsp_valid
- fpu_start  out  1  one-cycle issue pulse to the FPU
- fpu_op  out  4  ALUOp to the FPU
- fpu_a  out  32  operand A to the FPU
- fpu_b  out  32  operand B to the FPU
- fpu_result  in  32  FPU result
- fpu_valid  in  1  FPU result-valid pulse
- busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock, CLK. reset is synchronous and active-high.
- Reset values: every output is 0. State=IDLE, rr_last=1 (requester 0 wins first), latched regs=0, timeout counter=0.
- Supported ALUOp values:
  - 0011 fadd, 0100 fsub, 1110 fmul, 1101 fdiv
  - 1100 fceq, 1011 fcle, 1010 fclt
  - Every other code is unsupported.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester other than rr_last is granted.
  - req_ready[g] is asserted combinationally in the same cycle and is only ever asserted in IDLE.
  - On grant, latch op, a, b, tag and src=g, set rr_last=g, go to ISSUE.
- ISSUE, supported op: fpu_start=1 for exactly one cycle, then go to WAIT.
- ISSUE, unsupported op: no fpu_start; go directly to RESP with err=1 and data=0.
- fpu_op, fpu_a and fpu_b are held stable from ISSUE through the end of WAIT, and are 0 otherwise.
- WAIT: when fpu_valid=1, capture fpu_result, set err=0, go to RESP.
- fpu_valid seen in any state other than WAIT is ignored.
- RESP:
  - rsp_valid[src]=1 for one cycle, with rsp_data, rsp_tag and rsp_err driven.
  - rsp_data, rsp_tag and rsp_err are 0 whenever rsp_valid=0.
  - Then go to IDLE.
  - There is no accept in RESP, so one dead cycle separates back-to-back ops.
- Latency: accept at cycle t; fpu_start at t+1; FPU returns at t+1+L (L≥1); rsp_valid at t+2+L.
- Unsupported op: accept at t, rsp_valid at t+2.
- Requester stability: a requester holds its valid/op/a/b/tag until accepted. Deasserting req_valid before acceptance withdraws the request; no error results.
- Reset mid-operation: the outstanding op is dropped with no response. Any late fpu_valid after reset is ignored because state is IDLE.
- Only one op is ever outstanding; there is no queuing.

Optional Feature:
- Macro FPU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without fpu_valid.
  - When the count reaches TIMEOUT_CYCLES-1 with fpu_valid still low, go to RESP with err=1 and data=0.
  - If fpu_valid arrives on that same cycle, it wins and err=0.
  - A later stray fpu_valid is ignored.
- Undefined: no counter; WAIT lasts indefinitely.

Test Plan:
- Single request: req0 fadd 0x3F800000+0x40000000, FPU model L=3 returns 0x40400000 → fpu_start at t+1, rsp_valid=01 at t+5, rsp_data=0x40400000, tag echoed, rsp_err=0.
- Contention: req_valid=11 held continuously for 4 ops → grants alternate 0,1,0,1 (first grant 0); each rsp_valid routes to the matching source and tag.
- Compare op: req1 fclt 1.0<2.0, FPU returns 0x00000001 → rsp_valid=10, rsp_data=0x00000001.
- Unsupported op 4'b0000 on req0 → no fpu_start, rsp_valid=01 at t+2, rsp_err=1, rsp_data=0; a stray fpu_valid in IDLE produces no response.
- Reset asserted during WAIT, then fpu_valid pulses → no rsp_valid, busy=0, next request granted to req0 first.
- FPU_TIMEOUT_EN, TIMEOUT_CYCLES=8, FPU never responds → rsp_err=1 exactly 8 WAIT cycles after fpu_start; a late fpu_valid is ignored.
